result_writer: RTL



---
 rtl/result_writer_pkg.sv | 13 +
 rtl/result_writer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/result_writer_pkg.sv
// Shared training definitions: sweep geometry, counter width and write-back FSM states.
package result_writer_pkg;
  localparam int N_SAMPLES = 150;
  localparam int ADDR_W    = 8;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CLOSE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/result_writer.sv
// Writes per-sample error bits to the result RAM, counts errors per epoch and
// decides when training stops (zero-error epoch or epoch limit); one bubble between epochs.
module result_writer #(
  parameter int N_SAMPLES  = result_writer_pkg::N_SAMPLES,
  parameter int ADDR_W     = result_writer_pkg::ADDR_W,
  parameter int MAX_EPOCHS = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              res_valid,
  input  logic              res_err,
  output logic              res_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic [7:0]        err_cnt,
  output logic [7:0]        epoch,
  output logic              epoch_done,
  output logic              converged,
  output logic              busy
);
  import result_writer_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  MAX_EP    = CNT_W'(MAX_EPOCHS);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_run_err;
  logic [CNT_W-1:0]    r_err_cnt;
  logic [CNT_W-1:0]    r_epoch;
  logic                r_converged;
  logic                r_epoch_done;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_wr_data;
  logic                w_accept;
  logic                w_last;
  logic [CNT_W-1:0]    w_epoch_inc;

  assign w_accept    = res_valid && (r_state == S_COLLECT);
  assign w_last      = (r_addr == LAST_ADDR);
  assign w_epoch_inc = r_epoch + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_COLLECT;
      S_COLLECT:      if (w_accept && w_last) w_next = S_CLOSE;
      S_CLOSE: begin
        if (r_run_err == '0 || w_epoch_inc == MAX_EP) w_next = S_DONE;
        else                                          w_next = S_COLLECT;
      end
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_run_err    <= '0;
      r_err_cnt    <= '0;
      r_epoch      <= '0;
      r_converged  <= 1'b0;
      r_epoch_done <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_epoch_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_addr      <= '0;
            r_run_err   <= '0;
            r_epoch     <= '0;
            r_err_cnt   <= '0;
            r_converged <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= res_err;
            r_run_err <= r_run_err + CNT_W'(res_err);
            if (!w_last) r_addr <= r_addr + ADDR_W'(1);
          end
        end
        S_CLOSE: begin
          // err_cnt samples run_err before the clear below takes effect
          r_err_cnt    <= r_run_err;
          r_epoch      <= w_epoch_inc;
          r_epoch_done <= 1'b1;
          if (r_run_err == '0) r_converged <= 1'b1;
          r_addr       <= '0;
          r_run_err    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign res_ready  = (r_state == S_COLLECT);
  assign busy       = (r_state == S_COLLECT) || (r_state == S_CLOSE);
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign err_cnt    = r_err_cnt;
  assign epoch      = r_epoch;
  assign epoch_done = r_epoch_done;
  assign converged  = r_converged;
endmodule
